uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares the single uart_tx instance between NUM_REQ byte producers.
//  Round-robin arbitration; drives uart_tx_en/uart_tx_data and tracks uart_tx_busy.
//  Each request is sent either as a raw byte or as two upper-case ASCII hex characters.
//  Sits between the application FSMs (echo, status dump, ...) and uart_tx.
// PARAMETERS
//  NUM_REQ        2   number of requesters (1..8)
//  WAIT_BUSY_MAX  16  cycles to wait for uart_tx_busy to rise before abandoning the character
// PORTS
//  CLK            in   1          system clock
//  resetn         in   1          synchronous reset, active low
//  req_valid      in   NUM_REQ    request i pending; held until req_ready[i] is seen
//  req_hex        in   NUM_REQ    1: send req_data as 2 hex chars, 0: raw byte
//  req_data       in   8*NUM_REQ  byte for requester i, in bits [8i+7:8i]
//  req_ready      out  NUM_REQ    one-cycle pulse: request i accepted (data captured this edge)
//  uart_tx_en     out  1          start strobe to uart_tx
//  uart_tx_data   out  8          character to uart_tx
//  uart_tx_busy   in   1          uart_tx transmitting
//  sched_busy     out  1          1 whenever state != IDLE
//  timeout        out  1          one-cycle pulse: uart_tx_busy failed to rise in time
// BEHAVIOUR
//  - Reset (resetn=0 at a CLK edge): state IDLE, rr pointer = NUM_REQ-1 (req 0 wins first);
//    all outputs 0; captured byte, hex flag and nibble flag cleared.
//    Reset mid-transfer drops the rest of the request; a character already started in uart_tx completes.
//  - States:
//    - IDLE
//      - grants only when some req_valid=1 and uart_tx_busy=0.
//      - req_ready[g] is combinational in IDLE.
//      - At that edge: capture data and hex flag; set nibble=HI; go to SEND.
//    - SEND
//      - uart_tx_en=1 with uart_tx_data = current char; wait counter increments.
//      - uart_tx_busy=1 -> DRAIN.
//      - counter reaches WAIT_BUSY_MAX -> IDLE with timeout=1 for one cycle; request dropped.
//    - DRAIN
//      - uart_tx_en=0; uart_tx_data held.
//      - uart_tx_busy=0 and hex and nibble=HI -> nibble=LO, back to SEND.
//      - Otherwise, uart_tx_busy=0 -> IDLE.
//  - Latency: req_ready pulse in cycle 0; uart_tx_en first high in cycle 1.
//    Next grant no earlier than 1 cycle after returning to IDLE.
//  - Current char:
//    - raw: captured byte.
//    - hex: nibble 0-9 -> 0x30+n, A-F -> 0x37+n; HI nibble first.
//  - Round robin: search starts at pointer+1 mod NUM_REQ; pointer := g on grant.
//    Simultaneous requests are therefore served in rotation. Requests are never starved.
//  - uart_tx_data is 0 in IDLE. It is stable from SEND entry until DRAIN exit.
//  - Wait counter clears on every SEND entry.
//  - Dropping req_valid before req_ready is legal: the request is simply not granted.
// CONFIGURATION
//  UART_TX_SCHED_HEX_EN
//    - defined: hex mode as above.
//    - undefined: req_hex is ignored and every request is one raw byte; no nibble flag and no ASCII logic.
// STRUCTURE
//  - Package uart_tx_sched_pkg:
//    - state localparams IDLE/SEND/DRAIN (2 bits)
//    - HEX_ASCII_OFS_DIGIT=8'h30 and HEX_ASCII_OFS_ALPHA=8'h37
//    - function nib2ascii
//  - Sub-module rr_arbiter (NUM_REQ): inputs req vector, pointer and enable; outputs one-hot grant and index.
//  - The FSM, capture registers and wait counter ($clog2(WAIT_BUSY_MAX+1) bits) stay in uart_tx_sched.
// TESTING
//  - uart_tx model: busy rises 2 cycles after en, stays high for 20 cycles.
//  1. Raw: req0 valid, hex=0, data=0x41 -> req_ready=01 once; en high for 2 cycles with data 0x41; idle after busy falls.
//  2. Hex: req1 valid, hex=1, data=0x3C -> two transfers, 0x33 then 0x43; one req_ready pulse only.
//  3. Contention: both held valid for 4 transfers from reset (raw 0x10/0x20) -> order 0x10, 0x20, 0x10, 0x20.
//  4. Timeout: model never raises busy; req0 0x55 -> en high 16 cycles, timeout pulse, IDLE; next request served normally.
//  5. Reset mid-hex: resetn=0 during DRAIN of 1st char of 0xAB -> no 0x42 sent; all outputs 0 the next cycle.
//  6. Macro off: req0 hex=1, data=0x3C -> single transfer of 0x3C.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and helpers for the uart_tx scheduler.
// Optional hex output is enabled by defining UART_TX_SCHED_HEX_EN.
package uart_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0] HEX_ASCII_OFS_DIGIT = 8'h30;
  localparam logic [7:0] HEX_ASCII_OFS_ALPHA = 8'h37;

  // Upper-case ASCII hex digit for one nibble.
  function automatic logic [7:0] nib2ascii(input logic [3:0] i_nib);
    if (i_nib < 4'd10) begin
      return HEX_ASCII_OFS_DIGIT + {4'h0, i_nib};
    end
    return HEX_ASCII_OFS_ALPHA + {4'h0, i_nib};
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin arbiter: search starts one past the last winner.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDXW-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDXW-1:0]    o_idx
);

  logic            w_found;
  logic [IDXW-1:0] w_cand;

  // Scan requesters in rotation order and take the first pending one.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IDXW'((32'(i_ptr) + k) % NUM_REQ);
      if (i_en && !w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one uart_tx between NUM_REQ byte producers (round-robin).
// Define UART_TX_SCHED_HEX_EN to send requests as two ASCII hex chars
// when req_hex is set; otherwise every request is one raw byte.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ       = 2,
  parameter int WAIT_BUSY_MAX = 16
) (
  input  logic                 CLK,
  input  logic                 resetn,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_hex,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 uart_tx_en,
  output logic [7:0]           uart_tx_data,
  input  logic                 uart_tx_busy,
  output logic                 sched_busy,
  output logic                 timeout
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNTW = $clog2(WAIT_BUSY_MAX + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDXW-1:0]   r_ptr;
  logic [7:0]        r_byte;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_nxt;
  logic              r_timeout;
  logic              w_timeout_set;
  logic              w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IDXW-1:0]   w_idx;
  logic              w_any;
  logic [7:0]        w_sel_byte;
  logic [7:0]        w_char;
  logic              w_last_char;

`ifdef UART_TX_SCHED_HEX_EN
  logic r_hex;
  logic r_nib_lo;
  logic w_sel_hex;
`else
  logic w_unused_hex;
  assign w_unused_hex = ^req_hex;
`endif

  // Grants are only offered while idle, out of reset, with uart_tx free.
  assign w_arb_en = (r_state == IDLE) && !uart_tx_busy && resetn;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDXW    (IDXW)
  ) u_arb (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign w_any     = |w_grant;
  assign w_cnt_nxt = r_cnt + CNTW'(1);

  // Select the granted requester's byte (and hex flag).
  always_comb begin
    w_sel_byte = '0;
`ifdef UART_TX_SCHED_HEX_EN
    w_sel_hex  = |(w_grant & req_hex);
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_grant[k]) begin
        w_sel_byte = req_data[8*k +: 8];
      end
    end
  end

  // Current character and whether it is the final one of the request.
  always_comb begin
`ifdef UART_TX_SCHED_HEX_EN
    if (r_hex) begin
      w_char = nib2ascii(r_nib_lo ? r_byte[3:0] : r_byte[7:4]);
    end else begin
      w_char = r_byte;
    end
    w_last_char = !r_hex || r_nib_lo;
`else
    w_char      = r_byte;
    w_last_char = 1'b1;
`endif
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt   = r_state;
    w_timeout_set = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (uart_tx_busy) begin
          w_state_nxt = DRAIN;
        end else if (w_cnt_nxt == CNTW'(WAIT_BUSY_MAX)) begin
          w_state_nxt   = IDLE;
          w_timeout_set = 1'b1;
        end
      end
      DRAIN: begin
        if (!uart_tx_busy) begin
          w_state_nxt = w_last_char ? IDLE : SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, capture registers, wait counter and timeout pulse.
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_ptr     <= IDXW'(NUM_REQ - 1);
      r_byte    <= '0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
`ifdef UART_TX_SCHED_HEX_EN
      r_hex     <= 1'b0;
      r_nib_lo  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_timeout_set;
      if (w_any) begin
        r_byte <= w_sel_byte;
        r_ptr  <= w_idx;
`ifdef UART_TX_SCHED_HEX_EN
        r_hex    <= w_sel_hex;
        r_nib_lo <= 1'b0;
`endif
      end
      if (w_state_nxt == SEND && r_state != SEND) begin
        r_cnt <= '0;
      end else if (r_state == SEND) begin
        r_cnt <= w_cnt_nxt;
      end
`ifdef UART_TX_SCHED_HEX_EN
      if (r_state == DRAIN && !uart_tx_busy && !w_last_char) begin
        r_nib_lo <= 1'b1;
      end
`endif
    end
  end

  assign req_ready    = w_grant;
  assign uart_tx_en   = (r_state == SEND);
  assign uart_tx_data = (r_state == IDLE) ? 8'h00 : w_char;
  assign sched_busy   = (r_state != IDLE);
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched (NUM_REQ=2, WAIT_BUSY_MAX=16).
module tb_uart_tx_sched;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [1:0]  req_valid;
  logic [1:0]  req_hex;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        uart_tx_en;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic        sched_busy;
  logic        timeout;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  uart_tx_sched #(
    .NUM_REQ       (2),
    .WAIT_BUSY_MAX (16)
  ) dut (
    .CLK          (CLK),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_hex      (req_hex),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .uart_tx_en   (uart_tx_en),
    .uart_tx_data (uart_tx_data),
    .uart_tx_busy (uart_tx_busy),
    .sched_busy   (sched_busy),
    .timeout      (timeout)
  );

  // uart_tx model: busy from the edge after en is seen, for 20 cycles.
  int         m_cnt   = 0;
  bit         m_never = 1'b0;
  logic [7:0] q_chars[$];
  int         n_en = 0, n_rdy0 = 0, n_rdy1 = 0, n_to = 0;

  assign uart_tx_busy = (m_cnt != 0);

  always @(posedge CLK) begin
    if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
    end else if (uart_tx_en && !m_never) begin
      m_cnt <= 20;
      q_chars.push_back(uart_tx_data);
    end
    if (uart_tx_en)   n_en++;
    if (req_ready[0]) n_rdy0++;
    if (req_ready[1]) n_rdy1++;
    if (timeout)      n_to++;
  end

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK);
      #1;
      if (!sched_busy && !uart_tx_busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge CLK);
    resetn    = 1'b0;
    req_valid = 2'b01;
    req_hex   = 2'b00;
    req_data  = 16'h0000;
    repeat (2) @(negedge CLK);
    #1;
    n_total++;
    if ({req_ready, uart_tx_en, uart_tx_data, sched_busy, timeout} !== 13'h0)
      $display("FAIL reset_outputs: got %h expected 0",
               {req_ready, uart_tx_en, uart_tx_data, sched_busy, timeout});
    else n_pass++;
    req_valid = 2'b00;
    @(negedge CLK);
    resetn = 1'b1;
  endtask

  task automatic test_raw();
    int e0, r0, r1, c0;
    bit ok;
    logic [7:0] ch;
    e0 = n_en; r0 = n_rdy0; r1 = n_rdy1; c0 = q_chars.size();
    @(negedge CLK);
    req_valid = 2'b01; req_hex = 2'b00; req_data = 16'h0041;
    #1;
    n_total++;
    if (req_ready !== 2'b01) $display("FAIL raw_ready: got %b expected 01", req_ready);
    else n_pass++;
    @(negedge CLK);
    req_valid = 2'b00;
    #1;
    n_total++;
    if ({uart_tx_en, uart_tx_data, sched_busy} !== 10'h283)
      $display("FAIL raw_send: got %h expected 283", {uart_tx_en, uart_tx_data, sched_busy});
    else n_pass++;
    wait_idle(100, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL raw_idle: got %b expected 1", ok);
    else n_pass++;
    n_total++;
    if ((n_rdy0 - r0) * 16 + (n_rdy1 - r1) !== 16)
      $display("FAIL raw_ready_count: got %0d/%0d expected 1/0", n_rdy0 - r0, n_rdy1 - r1);
    else n_pass++;
    n_total++;
    if (n_en - e0 !== 2) $display("FAIL raw_en_cycles: got %0d expected 2", n_en - e0);
    else n_pass++;
    ch = (q_chars.size() == c0 + 1) ? q_chars[c0] : 8'hxx;
    n_total++;
    if (ch !== 8'h41) $display("FAIL raw_char: got %h expected 41", ch);
    else n_pass++;
  endtask

`ifdef UART_TX_SCHED_HEX_EN
  task automatic test_hex();
    int e0, r1, c0;
    bit ok;
    logic [15:0] chs;
    e0 = n_en; r1 = n_rdy1; c0 = q_chars.size();
    @(negedge CLK);
    req_valid = 2'b10; req_hex = 2'b10; req_data = 16'h3C00;
    #1;
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL hex_ready: got %b expected 10", req_ready);
    else n_pass++;
    @(negedge CLK);
    req_valid = 2'b00;
    wait_idle(200, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL hex_idle: got %b expected 1", ok);
    else n_pass++;
    chs = (q_chars.size() == c0 + 2) ? {q_chars[c0], q_chars[c0+1]} : 16'hxxxx;
    n_total++;
    if (chs !== 16'h3343) $display("FAIL hex_chars: got %h expected 3343", chs);
    else n_pass++;
    n_total++;
    if (n_rdy1 - r1 !== 1) $display("FAIL hex_ready_count: got %0d expected 1", n_rdy1 - r1);
    else n_pass++;
    n_total++;
    if (n_en - e0 !== 4) $display("FAIL hex_en_cycles: got %0d expected 4", n_en - e0);
    else n_pass++;
  endtask
`else
  task automatic test_macro_off();
    int e0, c0;
    bit ok;
    logic [7:0] ch;
    e0 = n_en; c0 = q_chars.size();
    @(negedge CLK);
    req_valid = 2'b01; req_hex = 2'b01; req_data = 16'h003C;
    @(negedge CLK);
    req_valid = 2'b00;
    wait_idle(200, ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL off_idle: got %b expected 1", ok);
    else n_pass++;
    ch = (q_chars.size() == c0 + 1) ? q_chars[c0] : 8'hxx;
    n_total++;
    if (ch !== 8'h3C) $display("FAIL off_char: got %h expected 3c (count %0d)", ch, q_chars.size() - c0);
    else n_pass++;
    n_total++;
    if (n_en - e0 !== 2) $display("FAIL off_en_cycles: got %0d expected 2", n_en - e0);
    else n_pass++;
  endtask
`endif

  task automatic test_contention();
    int c0, ng;
    bit ok;
    logic [7:0] g;
    logic [31:0] chs;
    @(negedge CLK);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    c0 = q_chars.size();
    ng = 0; g = 8'h00;
    req_valid = 2'b11; req_hex = 2'b00; req_data = 16'h2010;
    for (int i = 0; i < 400 && ng < 4; i++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = {g[5:0], req_ready};
        ng++;
      end
      @(negedge CLK);
    end
    req_valid = 2'b00;
    n_total++;
    if (ng !== 4) $display("FAIL cont_grants: got %0d expected 4", ng);
    else n_pass++;
    n_total++;
    if (g !== 8'b01_10_01_10) $display("FAIL cont_order: got %b expected 01100110", g);
    else n_pass++;
    wait_idle(200, ok);
    chs = (q_chars.size() == c0 + 4) ?
          {q_chars[c0], q_chars[c0+1], q_chars[c0+2], q_chars[c0+3]} : 32'hxxxxxxxx;
    n_total++;
    if (chs !== 32'h10201020) $display("FAIL cont_chars: got %h expected 10201020", chs);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int e0, t0, c0;
    bit ok;
    logic [7:0] ch;
    e0 = n_en; t0 = n_to; c0 = q_chars.size();
    m_never = 1'b1;
    @(negedge CLK);
    req_valid = 2'b01; req_hex = 2'b00; req_data = 16'h0055;
    @(negedge CLK);
    req_valid = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!sched_busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_total++;
    if ({ok, timeout} !== 2'b11) $display("FAIL to_pulse: got %b expected 11", {ok, timeout});
    else n_pass++;
    @(negedge CLK);
    #1;
    n_total++;
    if (timeout !== 1'b0) $display("FAIL to_clear: got %b expected 0", timeout);
    else n_pass++;
    n_total++;
    if (n_en - e0 !== 16) $display("FAIL to_en_cycles: got %0d expected 16", n_en - e0);
    else n_pass++;
    n_total++;
    if (n_to - t0 !== 1) $display("FAIL to_count: got %0d expected 1", n_to - t0);
    else n_pass++;
    m_never = 1'b0;
    e0 = n_en;
    @(negedge CLK);
    req_valid = 2'b10; req_hex = 2'b00; req_data = 16'h7700;
    #1;
    n_total++;
    if (req_ready !== 2'b10) $display("FAIL to_next_ready: got %b expected 10", req_ready);
    else n_pass++;
    @(negedge CLK);
    req_valid = 2'b00;
    wait_idle(100, ok);
    ch = (q_chars.size() == c0 + 1) ? q_chars[c0] : 8'hxx;
    n_total++;
    if (ch !== 8'h77) $display("FAIL to_next_char: got %h expected 77", ch);
    else n_pass++;
    n_total++;
    if ({n_en - e0, n_to - t0} !== {32'd2, 32'd1})
      $display("FAIL to_next_counts: got en %0d to %0d expected 2 1", n_en - e0, n_to - t0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int c0;
    bit ok;
    logic [7:0] ch;
    logic [7:0] exp_ch;
    c0 = q_chars.size();
    @(negedge CLK);
    req_valid = 2'b01;
`ifdef UART_TX_SCHED_HEX_EN
    req_hex = 2'b01; req_data = 16'h00AB; exp_ch = 8'h41;
`else
    req_hex = 2'b00; req_data = 16'h005A; exp_ch = 8'h5A;
`endif
    @(negedge CLK);
    req_valid = 2'b00;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (sched_busy && !uart_tx_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_total++;
    if (ok !== 1'b1) $display("FAIL rst_mid_drain: got %b expected 1", ok);
    else n_pass++;
    resetn = 1'b0;
    @(negedge CLK);
    #1;
    n_total++;
    if ({req_ready, uart_tx_en, uart_tx_data, sched_busy, timeout} !== 13'h0)
      $display("FAIL rst_mid_outputs: got %h expected 0",
               {req_ready, uart_tx_en, uart_tx_data, sched_busy, timeout});
    else n_pass++;
    resetn = 1'b1;
    wait_idle(100, ok);
    repeat (3) @(negedge CLK);
    ch = (q_chars.size() == c0 + 1) ? q_chars[c0] : 8'hxx;
    n_total++;
    if (ch !== exp_ch)
      $display("FAIL rst_mid_chars: got %h (count %0d) expected %h", ch, q_chars.size() - c0, exp_ch);
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    resetn    = 1'b0;
    req_valid = 2'b00;
    req_hex   = 2'b00;
    req_data  = 16'h0000;
    test_reset();
    test_raw();
`ifdef UART_TX_SCHED_HEX_EN
    test_hex();
`else
    test_macro_off();
`endif
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
